behav_sram_1r1w_init: RTL and testbench

//  Parametrised behavioural 1-read/1-write SRAM model for Chisel-generated *_ext memory macros.
//  It generalises the fixed-size byte-masked models in these ways:
//   - configurable width, depth and mask granularity;
//   - selectable 1- or 2-cycle read latency with a registered read-valid;
//   - optional write-to-read bypass on same-address collisions;
//   - a hardware init FSM that zeroes every entry after reset, replacing RANDOMIZE_MEM_INIT.

---
 rtl/behav_sram_1r1w_init.sv | 146 ++++++++++++++
 tb/tb_behav_sram_1r1w_init.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/behav_sram_1r1w_init.sv
// Behavioural 1R1W SRAM with lane write mask, 1/2-cycle registered read,
// optional same-address write bypass and a post-reset zero-fill sequencer.
module behav_sram_1r1w_init #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 64,
    parameter int MASK_GRAN = 8,
    parameter int READ_LAT  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            W0_en,
    input  logic [ADDR_W-1:0]               W0_addr,
    input  logic [DATA_W-1:0]               W0_data,
    input  logic [DATA_W/MASK_GRAN-1:0]     W0_mask,
    input  logic                            R0_en,
    input  logic [ADDR_W-1:0]               R0_addr,
    output logic [DATA_W-1:0]               R0_data,
    output logic                            R0_valid,
    output logic                            init_done
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int MASK_W = DATA_W / MASK_GRAN;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if ((DATA_W % MASK_GRAN) != 0) begin : g_bad_gran
        $error("behav_sram_1r1w_init: DATA_W must be a multiple of MASK_GRAN");
    end
    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
        $error("behav_sram_1r1w_init: READ_LAT must be 1 or 2");
    end

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                init_done_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                ready;
    logic                init_wr;
    logic                wr_fire;
    logic                rd_fire;
    logic [DATA_W-1:0]   wr_bitmask;
    logic [DATA_W-1:0]   rd_word;

    logic                out_vld_d;
    logic [DATA_W-1:0]   out_data_d;
    logic                R0_valid_q;
    logic [DATA_W-1:0]   R0_data_q;

    assign ready   = (state_q == ST_READY);
    assign init_wr = (state_q == ST_INIT) && !reset;
    assign wr_fire = ready && W0_en;
    assign rd_fire = ready && R0_en;

    // Zero-fill sequencer: one entry per cycle, then parks in READY until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else if (state_q == ST_INIT) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_q     <= ST_READY;
                init_done_q <= 1'b1;
            end
        end
    end

    // Lane-enabled write so FPGA tools can map the mask onto byte enables.
    always_ff @(posedge clock) begin
        if (init_wr) begin
            mem[cnt_q] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (W0_mask[i]) begin
                    mem[W0_addr][i*MASK_GRAN +: MASK_GRAN] <= W0_data[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    always_comb begin
        wr_bitmask = '0;
        for (int i = 0; i < MASK_W; i++) begin
            wr_bitmask[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{W0_mask[i]}};
        end
    end

    always_comb begin
        rd_word = mem[R0_addr];
        if ((BYPASS != 0) && wr_fire && (W0_addr == R0_addr)) begin
            rd_word = (rd_word & ~wr_bitmask) | (W0_data & wr_bitmask);
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic                s1_vld_q;
        logic [DATA_W-1:0]   s1_data_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                s1_vld_q <= 1'b0;
            end else begin
                s1_vld_q <= rd_fire;
            end
        end

        always_ff @(posedge clock) begin
            if (rd_fire) begin
                s1_data_q <= rd_word;
            end
        end

        assign out_vld_d  = s1_vld_q;
        assign out_data_d = s1_data_q;
    end else begin : g_lat1
        assign out_vld_d  = rd_fire;
        assign out_data_d = rd_word;
    end

    // Output register: data only moves on a valid beat so it holds between reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            R0_valid_q <= 1'b0;
            R0_data_q  <= '0;
        end else begin
            R0_valid_q <= out_vld_d;
            if (out_vld_d) begin
                R0_data_q <= out_data_d;
            end
        end
    end

    assign R0_data   = R0_data_q;
    assign R0_valid  = R0_valid_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_behav_sram_1r1w_init.sv
// Directed bench driving three SRAM variants in lockstep:
// (READ_LAT=1,BYPASS=1), (READ_LAT=1,BYPASS=0), (READ_LAT=2,BYPASS=1).
module tb_behav_sram_1r1w_init;

    logic        clock = 1'b0;
    logic        reset;
    logic        w_en;
    logic [8:0]  w_addr;
    logic [63:0] w_data;
    logic [7:0]  w_mask;
    logic        r_en;
    logic [8:0]  r_addr;

    logic [63:0] d1_data, b0_data, l2_data;
    logic        d1_vld, b0_vld, l2_vld;
    logic        d1_done, b0_done, l2_done;

    int vectors = 0;
    int errors  = 0;

    always #5 clock = ~clock;

    behav_sram_1r1w_init #(.ADDR_W(9), .DATA_W(64), .MASK_GRAN(8), .READ_LAT(1), .BYPASS(1)) dut_d1 (
        .clock(clock), .reset(reset),
        .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data), .W0_mask(w_mask),
        .R0_en(r_en), .R0_addr(r_addr),
        .R0_data(d1_data), .R0_valid(d1_vld), .init_done(d1_done)
    );

    behav_sram_1r1w_init #(.ADDR_W(9), .DATA_W(64), .MASK_GRAN(8), .READ_LAT(1), .BYPASS(0)) dut_b0 (
        .clock(clock), .reset(reset),
        .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data), .W0_mask(w_mask),
        .R0_en(r_en), .R0_addr(r_addr),
        .R0_data(b0_data), .R0_valid(b0_vld), .init_done(b0_done)
    );

    behav_sram_1r1w_init #(.ADDR_W(9), .DATA_W(64), .MASK_GRAN(8), .READ_LAT(2), .BYPASS(1)) dut_l2 (
        .clock(clock), .reset(reset),
        .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data), .W0_mask(w_mask),
        .R0_en(r_en), .R0_addr(r_addr),
        .R0_data(l2_data), .R0_valid(l2_vld), .init_done(l2_done)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [8:0] a, input logic [63:0] d, input logic [7:0] m);
        w_en = 1'b1; w_addr = a; w_data = d; w_mask = m;
        tick();
        w_en = 1'b0;
    endtask

    // Single read: LAT1 variants answer after this edge, LAT2 after the next.
    task automatic rd(input string tag, input logic [8:0] a, input logic [63:0] exp);
        r_en = 1'b1; r_addr = a;
        tick();
        r_en = 1'b0;
        chk({tag, "_d1_vld"}, 64'(d1_vld), 64'd1);
        chk({tag, "_d1_data"}, d1_data, exp);
        chk({tag, "_b0_data"}, b0_data, exp);
        chk({tag, "_l2_early"}, 64'(l2_vld), 64'd0);
        tick();
        chk({tag, "_d1_pulse"}, 64'(d1_vld), 64'd0);
        chk({tag, "_l2_vld"}, 64'(l2_vld), 64'd1);
        chk({tag, "_l2_data"}, l2_data, exp);
    endtask

    initial begin
        int bad_done;
        int bad_vld;
        int edges;

        reset = 1'b1;
        w_en = 1'b0; w_addr = '0; w_data = '0; w_mask = '0;
        r_en = 1'b0; r_addr = '0;
        tick(); tick(); tick();
        chk("rst_done",  64'({d1_done, b0_done, l2_done}), 64'd0);
        chk("rst_vld",   64'({d1_vld, b0_vld, l2_vld}), 64'd0);
        chk("rst_data",  d1_data | b0_data | l2_data, 64'd0);

        // Zero-fill with a write and a continuous read request that must be ignored.
        reset    = 1'b0;
        bad_done = 0;
        bad_vld  = 0;
        for (int n = 1; n <= 512; n++) begin
            w_en = (n == 5); w_addr = 9'h010; w_data = 64'hDEAD; w_mask = 8'hFF;
            r_en = 1'b1; r_addr = 9'h010;
            tick();
            w_en = 1'b0;
            if (n < 512 && (d1_done || b0_done || l2_done)) bad_done++;
            if (d1_vld || b0_vld || l2_vld) bad_vld++;
        end
        r_en = 1'b0;
        chk("init_done_early", 64'(bad_done), 64'd0);
        chk("vld_during_init", 64'(bad_vld), 64'd0);
        chk("init_done_512",   64'({d1_done, b0_done, l2_done}), 64'h7);

        rd("rd_000", 9'h000, 64'd0);
        rd("rd_1ff", 9'h1FF, 64'd0);
        rd("rd_010", 9'h010, 64'd0);

        // Lane mask merge
        wr(9'h020, 64'h1111_2222_3333_4444, 8'hFF);
        wr(9'h020, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
        rd("mask", 9'h020, 64'h1111_2222_CCCC_DDDD);
        wr(9'h020, 64'h9999_9999_9999_9999, 8'h00);
        rd("mask0", 9'h020, 64'h1111_2222_CCCC_DDDD);

        // Same-address collision on 0x030 (holds 0)
        w_en = 1'b1; w_addr = 9'h030; w_data = 64'hFFFF_FFFF_FFFF_FFFF; w_mask = 8'hF0;
        r_en = 1'b1; r_addr = 9'h030;
        tick();
        w_en = 1'b0; r_en = 1'b0;
        chk("coll_d1", d1_data, 64'hFFFF_FFFF_0000_0000);
        chk("coll_b0", b0_data, 64'd0);
        chk("coll_b0_vld", 64'(b0_vld), 64'd1);
        tick();
        chk("coll_l2", l2_data, 64'hFFFF_FFFF_0000_0000);
        rd("raw_030", 9'h030, 64'hFFFF_FFFF_0000_0000);

        // Different-address write and read on the same edge
        w_en = 1'b1; w_addr = 9'h040; w_data = 64'h5555_6666_7777_8888; w_mask = 8'hFF;
        r_en = 1'b1; r_addr = 9'h020;
        tick();
        w_en = 1'b0; r_en = 1'b0;
        chk("diff_d1", d1_data, 64'h1111_2222_CCCC_DDDD);
        chk("diff_b0", b0_data, 64'h1111_2222_CCCC_DDDD);
        tick();
        chk("diff_l2", l2_data, 64'h1111_2222_CCCC_DDDD);
        rd("rd_040", 9'h040, 64'h5555_6666_7777_8888);

        // Back-to-back reads of 0x001..0x003
        wr(9'h001, 64'h0000_0000_0000_0011, 8'hFF);
        wr(9'h002, 64'h0000_0000_0000_0022, 8'hFF);
        wr(9'h003, 64'h0000_0000_0000_0033, 8'hFF);
        r_en = 1'b1; r_addr = 9'h001;
        tick();
        chk("b2b_t_d1",    d1_data, 64'h11);
        chk("b2b_t_l2vld", 64'(l2_vld), 64'd0);
        r_addr = 9'h002;
        tick();
        chk("b2b_t1_d1",   d1_data, 64'h22);
        chk("b2b_t1_l2",   {l2_data[62:0], l2_vld}, {63'h11, 1'b1});
        r_addr = 9'h003;
        tick();
        r_en = 1'b0;
        chk("b2b_t2_l2",   {l2_data[62:0], l2_vld}, {63'h22, 1'b1});
        tick();
        chk("b2b_t3_l2",   {l2_data[62:0], l2_vld}, {63'h33, 1'b1});
        chk("b2b_t3_d1vld", 64'(d1_vld), 64'd0);
        tick();
        chk("b2b_t4_l2",   {l2_data[62:0], l2_vld}, {63'h33, 1'b0});

        // Reset one cycle after a LAT2 read
        r_en = 1'b1; r_addr = 9'h001;
        tick();
        r_en  = 1'b0;
        reset = 1'b1;
        tick();
        chk("mrst_l2vld", 64'(l2_vld), 64'd0);
        chk("mrst_data",  d1_data | b0_data | l2_data, 64'd0);
        chk("mrst_done",  64'({d1_done, b0_done, l2_done}), 64'd0);
        reset   = 1'b0;
        edges   = 0;
        bad_vld = 0;
        for (int n = 1; n <= 600 && !l2_done; n++) begin
            tick();
            edges = n;
            if (d1_vld || b0_vld || l2_vld) bad_vld++;
        end
        chk("mrst_no_vld", 64'(bad_vld), 64'd0);
        chk("mrst_reinit_edges", 64'(edges), 64'd512);
        rd("mrst_rd_001", 9'h001, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
